// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP substituted for
// faulting fetches, and the layout of one fetch-queue entry.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small register FIFO for the fetch queue. Entry 0 is always the head, so the
// head is a plain register; a flush clears occupancy but leaves the data alone.
module riscv_fetch_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d, kept_s;
  logic             do_pop_s, do_push_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = data_q[0];

  // Next occupancy and contents: pop shifts toward the head, push lands after the survivors.
  always_comb begin
    data_d    = data_q;
    count_d   = count_q;
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    kept_s    = count_q - CW'(do_pop_s);
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (do_pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i + 1];
        end
      end else begin
        data_d = data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = (do_push_s && (kept_s == CW'(i))) ? push_data_i : data_d[i];
      end
      count_d = kept_s + CW'(do_push_s);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: PC, one-outstanding I-cache requests, queue toward decode.
// Defining RISCV_FETCH_SKID_EN gives a two-entry queue so fetch can run one ahead.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  input  logic        fetch_invalidate_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        icache_invalidate_o
);

`ifdef RISCV_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inv_q;
  logic         fifo_full_s, fifo_empty_s;
  logic         push_s, pop_s, room_s, req_acc_s;
  fetch_entry_t push_entry_s, head_s;

  assign pop_s = fetch_accept_i & ~fifo_empty_s;
`ifdef RISCV_FETCH_SKID_EN
  assign room_s = ~fifo_full_s;
`else
  assign room_s = fifo_empty_s | pop_s;
`endif

  // Held low while reset is asserted so the request line reads idle immediately.
  assign icache_rd_o = (state_q == FETCH_IDLE) & room_s & ~rst_i;
  assign icache_pc_o = pc_q;
  assign req_acc_s   = icache_rd_o & icache_accept_i;

  // In WAIT the PC has already advanced past the outstanding request.
  assign push_s       = (state_q == FETCH_WAIT) & icache_valid_i & ~fetch_branch_i;
  assign push_entry_s = '{pc:    pc_q - 32'd4,
                          instr: icache_error_i ? INST_NOP : icache_inst_i,
                          fault: icache_error_i};

  // Next state and next PC; a redirect overrides sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH_IDLE: begin
        if (req_acc_s) state_d = fetch_branch_i ? FETCH_DRAIN : FETCH_WAIT;
        else           state_d = FETCH_IDLE;
      end
      FETCH_WAIT: begin
        if (icache_valid_i)      state_d = FETCH_IDLE;
        else if (fetch_branch_i) state_d = FETCH_DRAIN;
        else                     state_d = FETCH_WAIT;
      end
      FETCH_DRAIN: begin
        if (icache_valid_i) state_d = FETCH_IDLE;
        else                state_d = FETCH_DRAIN;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (fetch_branch_i)  pc_d = fetch_branch_pc_i & 32'hFFFF_FFFC;
    else if (req_acc_s)  pc_d = pc_q + 32'd4;
    else                 pc_d = pc_q;
  end

  // FSM, PC and invalidate registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH_IDLE;
      pc_q    <= BOOT_VECTOR & 32'hFFFF_FFFC;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inv_q   <= fetch_invalidate_i;
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (fetch_branch_i),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (head_s)
  );

  assign fetch_valid_o       = ~fifo_empty_s;
  assign fetch_pc_o          = head_s.pc;
  assign fetch_instr_o       = head_s.instr;
  assign fetch_fault_o       = head_s.fault;
  assign icache_invalidate_o = inv_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomised bench for riscv_fetch: cache model plus a scoreboard of the
// instructions decode should see, checked by an independent monitor.
module tb_riscv_fetch;

  localparam logic [31:0] BOOT = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef RISCV_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } cache_ent_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fetch_valid_o, fetch_fault_o, fetch_accept_i, fetch_branch_i, fetch_invalidate_i;
  logic [31:0] fetch_instr_o, fetch_pc_o, fetch_branch_pc_i;
  logic        icache_rd_o, icache_accept_i, icache_valid_i, icache_error_i, icache_invalidate_o;
  logic [31:0] icache_pc_o, icache_inst_i;

  always #5 clk = ~clk;

  riscv_fetch #(.BOOT_VECTOR(BOOT)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_fault_o       (fetch_fault_o),
    .fetch_accept_i      (fetch_accept_i),
    .fetch_branch_i      (fetch_branch_i),
    .fetch_branch_pc_i   (fetch_branch_pc_i),
    .fetch_invalidate_i  (fetch_invalidate_i),
    .icache_rd_o         (icache_rd_o),
    .icache_pc_o         (icache_pc_o),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_inst_i       (icache_inst_i),
    .icache_error_i      (icache_error_i),
    .icache_invalidate_o (icache_invalidate_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_req = 0;
  logic [31:0] model_pc;
  logic        prev_inv, prev_br;
  cache_ent_t  cache_q[$];
  logic [64:0] sb[$];
  logic [64:0] mon_exp;

  function automatic void chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Decode-side monitor: every consumed head must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (!rst_i && fetch_valid_o && fetch_accept_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected nothing", fetch_pc_o, fetch_instr_o);
      end else begin
        mon_exp = sb.pop_front();
        chk("decode_head", {fetch_pc_o, fetch_instr_o, fetch_fault_o}, mon_exp);
      end
    end
  end

  // One clock cycle of stimulus, cache behaviour and reference-model update.
  task automatic step(input bit dacc, input bit cacc, input bit rsp, input bit br,
                      input logic [31:0] bpc, input bit err, input bit inv);
    cache_ent_t ce;
    @(negedge clk);
    fetch_accept_i     = dacc;
    icache_accept_i    = cacc;
    fetch_branch_i     = br;
    fetch_branch_pc_i  = bpc;
    fetch_invalidate_i = inv;
    icache_valid_i     = rsp && (cache_q.size() != 0);
    icache_inst_i      = $urandom();
    icache_error_i     = err;
    #1;
    chk("invalidate", 65'(icache_invalidate_o), 65'(prev_inv));
    if (prev_br) chk("valid_after_redirect", 65'(fetch_valid_o), 65'(1'b0));
    prev_inv = inv;
    prev_br  = br;
    if (icache_valid_i) begin
      ce = cache_q.pop_front();
      if (!ce.stale && !br) sb.push_back({ce.pc, (err ? NOP : icache_inst_i), err});
    end
    if (icache_rd_o && cacc) begin
      chk("req_addr", 65'(icache_pc_o), 65'(model_pc));
      cache_q.push_back(cache_ent_t'{pc: model_pc, stale: br});
      chk("one_outstanding", 65'(cache_q.size() <= 1), 65'(1'b1));
      model_pc = model_pc + 32'd4;
      n_req++;
    end
    if (br) begin
      model_pc = bpc & 32'hFFFF_FFFC;
      for (int i = 0; i < cache_q.size(); i++) cache_q[i].stale = 1'b1;
    end
    #2;
    if (br) sb.delete();
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || cache_q.size() != 0) && k < 40) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk("drain_done", 65'(sb.size() + cache_q.size()), 65'(0));
  endtask

  task automatic check_reset_vals();
    chk("rst_valid", 65'(fetch_valid_o), 65'(1'b0));
    chk("rst_fault", 65'(fetch_fault_o), 65'(1'b0));
    chk("rst_inval", 65'(icache_invalidate_o), 65'(1'b0));
    chk("rst_instr", 65'(fetch_instr_o), 65'(32'h0));
    chk("rst_pc", 65'(fetch_pc_o), 65'(32'h0));
    chk("rst_rd", 65'(icache_rd_o), 65'(1'b0));
    chk("rst_icache_pc", 65'(icache_pc_o), 65'(BOOT));
  endtask

  int n0;

  initial begin
    rst_i = 1'b1;
    fetch_accept_i = 1'b0; fetch_branch_i = 1'b0; fetch_branch_pc_i = 32'h0;
    fetch_invalidate_i = 1'b0; icache_accept_i = 1'b0; icache_valid_i = 1'b0;
    icache_inst_i = 32'h0; icache_error_i = 1'b0;
    model_pc = BOOT; prev_inv = 1'b0; prev_br = 1'b0;
    #3;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rd_after_release", 65'(icache_rd_o), 65'(1'b1));
    chk("pc_after_release", 65'(icache_pc_o), 65'(BOOT));

    // Sequential fetch from the boot vector with a 1-cycle cache.
    run(12);

    // Decode stall: the queue fills to its depth and requests stop.
    drain();
    n0 = n_req;
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_reqs", 65'(n_req - n0), 65'(DEPTH));
    chk("stall_rd_low", 65'(icache_rd_o), 65'(1'b0));
    drain();

    // Redirect while a request is outstanding.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wait_outstanding", 65'(cache_q.size()), 65'(1));
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
    run(8);

    // Bus error at 0x40.
    drain();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run(6);

    // PC wrap.
    drain();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run(6);

    // Asynchronous reset with a request outstanding; its response arrives late.
    drain();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    check_reset_vals();
    icache_valid_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    icache_valid_i = 1'b1;
    icache_accept_i = 1'b0;
    fetch_accept_i = 1'b1;
    #1;
    chk("rd_after_rerelease", 65'(icache_rd_o), 65'(1'b1));
    chk("pc_after_rerelease", 65'(icache_pc_o), 65'(BOOT));
    cache_q.delete();
    sb.delete();
    model_pc = BOOT; prev_inv = 1'b0; prev_br = 1'b0;
    run(10);

    // Random traffic.
    repeat (800) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage directly upstream of `riscv_decode`. It holds the program counter and issues word-aligned reads to the instruction cache. It buffers returned instructions in a small output queue and presents them to decode with a valid/accept handshake. It applies branch redirects and forwards cache-invalidate requests.

## Interface
- `BOOT_VECTOR`, default 32'h0000_0000: PC after reset.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `fetch_valid_o` out 1: queue head valid toward decode.
- `fetch_instr_o` out 32: queue head instruction.
- `fetch_pc_o` out 32: queue head PC.
- `fetch_fault_o` out 1: queue head carries a bus error.
- `fetch_accept_i` in 1: decode consumes head when `fetch_valid_o & fetch_accept_i`.
- `fetch_branch_i` in 1: redirect request.
- `fetch_branch_pc_i` in 32: redirect target.
- `fetch_invalidate_i` in 1: request instruction-cache invalidate.
- `icache_rd_o` out 1: read request.
- `icache_pc_o` out 32: request address, bits [1:0] always 0.
- `icache_accept_i` in 1: request taken when `icache_rd_o & icache_accept_i`.
- `icache_valid_i` in 1: response valid; one response per accepted request, in order, earliest the cycle after acceptance.
- `icache_inst_i` in 32: response instruction.
- `icache_error_i` in 1: response bus error, qualified by `icache_valid_i`.
- `icache_invalidate_o` out 1: one-cycle invalidate pulse.

## Operation
- State register `pc_q`, reset `BOOT_VECTOR` with [1:0] forced 0. Increments by 4 when a request is accepted, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- FSM states:
  - IDLE: no request outstanding. Drives `icache_rd_o` = 1 when the queue has room, i.e. entries + outstanding < DEPTH. Goes to WAIT on accept.
  - WAIT: one request outstanding; `icache_rd_o` = 0. On response, writes {pc, instr, error} into the queue and goes to IDLE.
  - DRAIN: a redirect happened while a request was outstanding. The next response is discarded, then the FSM goes to IDLE.
- At most one request is outstanding at any time.
- Redirect (`fetch_branch_i`):
  - `pc_q` <= `fetch_branch_pc_i` with [1:0] cleared.
  - Queue is flushed.
  - WAIT goes to DRAIN. IDLE and DRAIN keep their state.
  - A request accepted in the same cycle is treated as outstanding-to-drain, so the FSM goes to DRAIN.
  - A response arriving in the same cycle as the redirect is discarded.
  - Redirect has priority over a simultaneous decode accept; the flush wins.
- Queue: FIFO of {pc[31:0], instr[31:0], fault}.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pop on an empty queue is ignored. Push is never attempted when full, by the issue rule above.
- Faulting responses are enqueued with `fetch_fault_o` = 1 and instr forced to 32'h0000_0013 (NOP). Fetch continues sequentially.
- `icache_invalidate_o` <= `fetch_invalidate_i`, registered.
- Reset mid-operation returns to IDLE with an empty queue. Any response in flight at that point is ignored, because IDLE discards responses.

## Timing
- Reset values of outputs:
  - `fetch_valid_o`, `fetch_fault_o`, `icache_invalidate_o`: 0.
  - `fetch_instr_o`, `fetch_pc_o`: 0.
  - `icache_rd_o`: 0, rising 1 in the first cycle after reset release.
  - `icache_pc_o`: `BOOT_VECTOR`.
- Queue outputs are driven from registers. A response in cycle M gives `fetch_valid_o` = 1 in M+1.
- Best-case throughput is one instruction every 2 cycles (request, then response).
- Redirect in cycle B:
  - `fetch_valid_o` = 0 in B+1.
  - If no request was outstanding, `icache_rd_o` = 1 with the target address in B+1.

## Configuration
- `RISCV_FETCH_SKID_EN` defined: queue DEPTH = 2. A response is absorbed while decode stalls with one entry held, so fetch continues one instruction ahead.
- `RISCV_FETCH_SKID_EN` undefined: DEPTH = 1. A new request issues only when the queue is empty or is being popped this cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - FSM state encodings `FETCH_IDLE`, `FETCH_WAIT`, `FETCH_DRAIN`.
  - `INST_NOP` = 32'h0000_0013.
- One sub-module, `riscv_fetch_fifo`: parametrised-depth register FIFO with flush, push, pop, full, empty and head outputs.

## Test plan
- Reset with `BOOT_VECTOR`=32'h8000_0000, cache accepting with 1-cycle response -> requests to 8000_0000, 8000_0004, …; decode sees the same PCs in order.
- Hold `fetch_accept_i`=0 for 10 cycles -> skid build: exactly 2 entries held, `icache_rd_o` stays 0; without the macro: 1 entry.
- Redirect to 32'h0000_0102 while in WAIT -> the in-flight response is dropped; next request is to 0000_0100; no stale PC ever reaches decode.
- Response with `icache_error_i`=1 at PC 0x40 -> `fetch_fault_o`=1, `fetch_instr_o`=0000_0013, `fetch_pc_o`=0x40; the next fetch is 0x44.
- PC 32'hFFFF_FFFC accepted -> next request to 0000_0000.
- `rst_i` asserted asynchronously while in WAIT -> outputs at reset values immediately; the late response is ignored; fetch restarts at `BOOT_VECTOR`.
